// File: rtl/pixel_fetch_if.sv
// Pixel fetch bus: frame-buffer read channel, serializer strobe and pixel outputs.
interface pixel_fetch_if;
  logic        newPixel;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        underflow;
  logic        frame_start;

  // fetch engine side
  modport master (
    input  newPixel, rd_valid, rd_data,
    output rd_req, rd_addr, red, green, blue, underflow, frame_start
  );

  // memory / serializer side
  modport slave (
    output newPixel, rd_valid, rd_data,
    input  rd_req, rd_addr, red, green, blue, underflow, frame_start
  );
endinterface

// File: rtl/pixel_fetch.sv
// Pixel fetch engine: prefetches frame-buffer pixels into a small FIFO and
// hands one pixel per serializer slot; a starved frame is flushed and refetched
// from address 0 so the next frame starts aligned.
module pixel_fetch #(
  parameter int HACTIVE    = 1280,
  parameter int HTOTAL     = 1441,
  parameter int VACTIVE    = 800,
  parameter int VTOTAL     = 824,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  pixel_fetch_if.master bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int DW   = CW + 1;
  localparam int HW   = $clog2(HTOTAL);
  localparam int VW   = $clog2(VTOTAL);
  localparam int NPIX = HACTIVE * VACTIVE;

  typedef enum logic [1:0] {RESET_WAIT, FILL, RUN, FLUSH} state_t;

  state_t          r_state, w_next;
  logic [HW-1:0]   r_hcnt, w_hnext;
  logic [VW-1:0]   r_vcnt, w_vnext;
  logic [CW-1:0]   r_count, r_out;
  logic [DW-1:0]   r_discard, w_drain;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [23:0]     r_mem [FIFO_DEPTH];
  logic [19:0]     r_addr;
  logic [23:0]     r_pix;
  logic            r_underflow, r_corrupt, r_fs;
  logic            w_hwrap, w_fwrap, w_new_active;
  logic            w_req, w_ret, w_stale, w_push, w_pop, w_take, w_starve;
  logic            w_pop_en, w_fill_done, w_flush_go, w_flush_done;

  assign w_hwrap      = (r_hcnt == HW'(HTOTAL - 1));
  assign w_fwrap      = w_hwrap && (r_vcnt == VW'(VTOTAL - 1));
  assign w_hnext      = w_hwrap ? '0 : r_hcnt + HW'(1);
  assign w_vnext      = w_fwrap ? '0 : (w_hwrap ? r_vcnt + VW'(1) : r_vcnt);
  assign w_new_active = (w_hnext < HW'(HACTIVE)) && (w_vnext < VW'(VACTIVE));

  // Request gating counts data in flight so the FIFO can never overflow.
  assign w_req   = rst_n && (r_state == FILL || r_state == RUN) &&
                   ({1'b0, r_count} + {1'b0, r_out} < DW'(FIFO_DEPTH));
  // Returns arrive in order, so pre-reset stragglers always come first.
  assign w_stale = bus.rd_valid && (r_discard != '0);
  assign w_ret   = bus.rd_valid && (r_discard == '0);
  assign w_push  = w_ret && (r_state != FLUSH);

  assign w_fill_done  = (r_state == FILL) && bus.newPixel && w_fwrap &&
                        (r_count == CW'(FIFO_DEPTH));
  assign w_flush_go   = (r_state == RUN) && bus.newPixel && w_fwrap && r_corrupt;
  assign w_flush_done = (r_state == FLUSH) && (r_out == '0) && (r_discard == '0);
  // The FILL->RUN edge already serves pixel (0,0) of the new frame.
  assign w_pop_en     = ((r_state == RUN) && !w_flush_go) || w_fill_done;
  assign w_take       = bus.newPixel && w_pop_en && w_new_active;
  assign w_pop        = w_take && (r_count != '0);
  assign w_starve     = w_take && (r_count == '0);
  // A held reset keeps accumulating stragglers rather than forgetting them.
  assign w_drain      = r_discard + DW'(r_out);

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n) r_state <= RESET_WAIT;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      RESET_WAIT: w_next = FILL;
      FILL:       if (w_fill_done)  w_next = RUN;
      RUN:        if (w_flush_go)   w_next = FLUSH;
      FLUSH:      if (w_flush_done) w_next = FILL;
      default:    w_next = RESET_WAIT;
    endcase
  end

  // Raster position, advanced once per serializer slot
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (bus.newPixel) begin
      r_hcnt <= w_hnext;
      r_vcnt <= w_vnext;
    end
  end

  // Outstanding reads and the count of stale returns to drop after reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_discard <= (bus.rd_valid && w_drain != '0) ? w_drain - DW'(1) : w_drain;
    end else begin
      if (w_req && !w_ret)      r_out <= r_out + CW'(1);
      else if (!w_req && w_ret) r_out <= r_out - CW'(1);
      if (w_stale) r_discard <= r_discard - DW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= bus.rd_data;
  end

  // FIFO pointers/occupancy and read address; flush restarts both at zero
  always_ff @(posedge clk_in) begin
    if (!rst_n || w_flush_done) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_req) r_addr <= (r_addr == 20'(NPIX - 1)) ? 20'd0 : r_addr + 20'd1;
    end
  end

  // Pixel output, frame marker and error flags
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_pix       <= '0;
      r_fs        <= 1'b0;
      r_underflow <= 1'b0;
      r_corrupt   <= 1'b0;
    end else begin
      r_fs <= bus.newPixel && w_pop_en && w_fwrap;
      if (bus.newPixel) r_pix <= w_pop ? r_mem[r_rptr] : 24'd0;
      if (w_flush_done) r_corrupt <= 1'b0;
      if (w_starve) begin
        r_underflow <= 1'b1;
        r_corrupt   <= 1'b1;
      end
    end
  end

  assign bus.rd_req      = w_req;
  assign bus.rd_addr     = r_addr;
  assign bus.red         = r_pix[23:16];
  assign bus.green       = r_pix[15:8];
  assign bus.blue        = r_pix[7:0];
  assign bus.underflow   = r_underflow;
  assign bus.frame_start = r_fs;
endmodule
